// File: rtl/uart_rx_frame.sv
//==============================================================================
// uart_rx_frame : parametrised UART receiver, 3-sample majority vote per bit,
//                 reports parity error, framing error and line break.
// Revision      : 1.0
//==============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Rx_Busy
);

    localparam logic [10:0] c_LAST_CNT  = 11'(CLKS_PER_BIT - 1);
    localparam logic [10:0] c_HALF      = 11'((CLKS_PER_BIT - 1) / 2);
    localparam logic [10:0] c_SAMP0     = c_HALF - 11'd1;
    localparam logic [10:0] c_EVAL      = c_HALF + 11'd1;
    localparam logic [3:0]  c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic        c_LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, rx_s_q;
    logic [10:0]            cnt_q, cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_q, par_d;
    logic                   ferr_q, ferr_d;
    logic                   dv_q, dv_d;
    logic [DATA_BITS-1:0]   byte_q, byte_d;
    logic                   perr_q, perr_d;
    logic                   frame_q, frame_d;
    logic                   brk_q, brk_d;

    logic                   w_maj;
    logic                   w_xor;
    logic                   w_par_err;
    logic                   w_frame_err;
    logic                   w_break;
    logic [10:0]            w_cnt_inc;

    // Third vote comes straight from the synchroniser at the evaluation count.
    assign w_maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign w_xor       = (^data_q) ^ par_q;
    assign w_par_err   = (PARITY == 1) ? ~w_xor : ((PARITY == 2) ? w_xor : 1'b0);
    assign w_frame_err = ferr_q | ~w_maj;
    assign w_break     = (data_q == '0) && !par_q && w_frame_err;
    assign w_cnt_inc   = (cnt_q == c_LAST_CNT) ? 11'd0 : cnt_q + 11'd1;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            frame_q    <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync1_q    <= i_Rx_Serial;
            rx_s_q     <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            perr_q     <= perr_d;
            frame_q    <= frame_d;
            brk_q      <= brk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        data_d     = data_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        perr_d     = perr_q;
        frame_d    = frame_q;
        brk_d      = brk_q;

        if (cnt_q == c_SAMP0) samp_d[0] = rx_s_q;
        if (cnt_q == c_HALF)  samp_d[1] = rx_s_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d    = S_START;
                    cnt_d      = 11'd1;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == c_EVAL && w_maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_LAST_CNT) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                cnt_d = w_cnt_inc;
                // LSB arrives first, so shifting right leaves it at bit 0.
                if (cnt_q == c_EVAL) data_d = {w_maj, data_q[DATA_BITS-1:1]};
                if (cnt_q == c_LAST_CNT) begin
                    if (bit_idx_q == c_LAST_BIT) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == c_EVAL) par_d = w_maj;
                if (cnt_q == c_LAST_CNT) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == c_EVAL) begin
                    ferr_d = w_frame_err;
                    if (stop_idx_q == c_LAST_STOP) begin
                        dv_d    = 1'b1;
                        byte_d  = data_q;
                        perr_d  = w_par_err;
                        frame_d = w_frame_err;
                        brk_d   = w_break;
                        cnt_d   = '0;
                        state_d = w_frame_err ? S_WAIT_IDLE : S_IDLE;
                    end
                end else if (cnt_q == c_LAST_CNT) begin
                    stop_idx_d = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = frame_q;
    assign o_Break      = brk_q;
    assign o_Rx_Busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire
